// File: rtl/register_file_be.sv
// Byte-lane writable register bank with two independent registered read ports
// and a per-entry dirty bitmap; reads bypass same-cycle writes per byte.
module register_file_be #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH/8-1:0]       wr_be,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en_a,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic                     rd_valid_a,
    input  logic                     rd_en_b,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_b,
    output logic                     rd_valid_b,
    output logic [(1<<ADDR_W)-1:0]   dirty
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                     input logic [WIDTH-1:0] new_word,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Write-first bypass per byte; a clearing cycle reads the pre-clear contents.
    always_comb begin
        wr_word   = merge_lanes(mem[wr_addr], wr_data, wr_be);
        rd_next_a = mem[rd_addr_a];
        rd_next_b = mem[rd_addr_b];
        if (wr_en && !clr && (wr_addr == rd_addr_a)) rd_next_a = merge_lanes(mem[rd_addr_a], wr_data, wr_be);
        if (wr_en && !clr && (wr_addr == rd_addr_b)) rd_next_b = merge_lanes(mem[rd_addr_b], wr_data, wr_be);
    end

    // Registered read stage and storage update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            dirty      <= '0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= rd_next_a;
            if (rd_en_b) rd_data_b <= rd_next_b;
            if (clr) begin
                for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
                dirty <= '0;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_word;
                if (|wr_be) dirty[wr_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_file_be.sv
// Scoreboard bench for register_file_be: driver pushes model expectations,
// monitor pops and compares one entry per clock.
module tb_register_file_be;

    logic        clk;
    logic        reset, clr, wr_en, rd_en_a, rd_en_b;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;
    logic [63:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [7:0]  dirty;

    // small instance for the narrow-parameter case
    logic        s_reset, s_wr_en, s_rd_en_a, s_rd_en_b;
    logic [1:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
    logic [1:0]  s_wr_be;
    logic [15:0] s_wr_data, s_rd_data_a, s_rd_data_b;
    logic        s_rd_valid_a, s_rd_valid_b;
    logic [3:0]  s_dirty;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic        va;
        logic [63:0] da;
        logic        vb;
        logic [63:0] db;
        logic [7:0]  dirty;
    } exp_t;
    exp_t exp_q[$];

    logic [63:0] m_mem [8];
    logic [63:0] m_da, m_db;
    logic        m_va, m_vb;
    logic [7:0]  m_dirty;

    register_file_be dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a), .rd_en_b(rd_en_b),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .dirty(dirty)
    );

    register_file_be #(.WIDTH(16), .ADDR_W(2)) dut_s (
        .clk(clk), .reset(s_reset), .clr(1'b0), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_be(s_wr_be), .wr_data(s_wr_data), .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a),
        .rd_data_a(s_rd_data_a), .rd_valid_a(s_rd_valid_a), .rd_en_b(s_rd_en_b),
        .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b), .rd_valid_b(s_rd_valid_b),
        .dirty(s_dirty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (be[i]) m = m | (64'hFF << (8 * i));
        return m;
    endfunction

    // One clock of stimulus; the model state is advanced and the expected outputs queued.
    task automatic step(input logic r, input logic c, input logic we, input logic [2:0] wa,
                        input logic [7:0] be, input logic [63:0] wd,
                        input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
        logic [63:0] mask, merged;
        exp_t e;
        @(negedge clk);
        reset = r; clr = c; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        if (r) begin
            for (int k = 0; k < 8; k++) m_mem[k] = '0;
            m_da = '0; m_db = '0; m_va = 0; m_vb = 0; m_dirty = '0;
        end else begin
            mask   = lane_mask(be);
            merged = (m_mem[wa] & ~mask) | (wd & mask);
            m_va = ea;
            m_vb = eb;
            if (ea) m_da = (we && !c && wa == aa) ? merged : m_mem[aa];
            if (eb) m_db = (we && !c && wa == ab) ? merged : m_mem[ab];
            if (c) begin
                for (int k = 0; k < 8; k++) m_mem[k] = '0;
                m_dirty = '0;
            end else if (we) begin
                m_mem[wa] = merged;
                if (be != 0) m_dirty[wa] = 1'b1;
            end
        end
        e.va = m_va; e.da = m_da; e.vb = m_vb; e.db = m_db; e.dirty = m_dirty;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid_a", {63'b0, rd_valid_a}, {63'b0, e.va});
                chk("rd_valid_b", {63'b0, rd_valid_b}, {63'b0, e.vb});
                chk("dirty", {56'b0, dirty}, {56'b0, e.dirty});
                if (e.va) chk("rd_data_a", rd_data_a, e.da);
                else      chk("rd_data_a_hold", rd_data_a, e.da);
                if (e.vb) chk("rd_data_b", rd_data_b, e.db);
                else      chk("rd_data_b_hold", rd_data_b, e.db);
            end
        end
    end

    initial begin
        logic [2:0] wa, aa, ab;
        int wait_cycles;
        reset = 1; clr = 0; wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        s_reset = 1; s_wr_en = 0; s_wr_addr = 0; s_wr_be = 0; s_wr_data = 0;
        s_rd_en_a = 0; s_rd_addr_a = 0; s_rd_en_b = 0; s_rd_addr_b = 0;
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        m_da = '0; m_db = '0; m_va = 0; m_vb = 0; m_dirty = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // T1: random writes and reads, then two reset cycles with random other inputs
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 3'($urandom), 8'($urandom), {$urandom, $urandom}, 1, 3'($urandom), 1, 3'($urandom));
        for (int i = 0; i < 2; i++)
            step(1, 1'($urandom), 1, 3'($urandom), 8'hFF, {$urandom, $urandom}, 1, 3'($urandom), 1, 3'($urandom));
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 0, 1, 3'(k), 1, 3'(7 - k));

        // T2: full write then low-half byte write to entry 3
        step(0, 0, 1, 3, 8'hFF, 64'h1122334455667788, 0, 0, 0, 0);
        step(0, 0, 1, 3, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);

        // T3: bypass on both ports into a zero entry
        step(0, 0, 1, 5, 8'h01, 64'hFF, 1, 5, 1, 5);
        idle();

        // T4: clear beats a same-cycle write; read in the clear cycle sees old data
        step(0, 0, 1, 2, 8'hFF, 64'h55, 0, 0, 0, 0);
        step(0, 1, 1, 2, 8'hFF, 64'h77, 1, 2, 1, 3);
        step(0, 0, 0, 0, 0, 0, 1, 2, 1, 3);

        // T5: hold with read disabled, zero-lane write
        step(0, 0, 1, 6, 8'hFF, 64'hDEADBEEF01234567, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        for (int i = 0; i < 3; i++) idle();
        step(0, 0, 1, 1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 0);
        step(0, 0, 1, 6, 8'h00, 64'h0, 1, 1, 1, 6);

        // Randomised traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            wa = 3'($urandom);
            aa = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), 1'($urandom), wa,
                 ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom},
                 1'($urandom), aa, 1'($urandom), ab);
        end
        idle();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // T6: 16-bit, 4-entry instance
        @(negedge clk);
        chk("s_reset_dirty", {60'b0, s_dirty}, 64'h0);
        s_reset = 0; s_wr_en = 1; s_wr_addr = 3; s_wr_be = 2'b10; s_wr_data = 16'hAB00;
        @(negedge clk);
        s_wr_en = 0; s_rd_en_a = 1; s_rd_addr_a = 3; s_rd_en_b = 1; s_rd_addr_b = 0;
        @(negedge clk);
        s_rd_en_a = 0; s_rd_en_b = 0;
        chk("s_rd_data_a", {48'b0, s_rd_data_a}, 64'hAB00);
        chk("s_rd_valid_a", {63'b0, s_rd_valid_a}, 64'h1);
        chk("s_rd_data_b", {48'b0, s_rd_data_b}, 64'h0);
        chk("s_dirty", {60'b0, s_dirty}, 64'h8);
        @(negedge clk);
        chk("s_rd_valid_a_drop", {63'b0, s_rd_valid_a}, 64'h0);
        chk("s_rd_data_a_hold", {48'b0, s_rd_data_a}, 64'hAB00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
